alarm_siren_controller: RTL and testbench
=========================================

# alarm_siren_controller

Downstream consumer of the home alarm core's `alarm` and `active` outputs. It adds an entry delay, drives a pulsed siren for a bounded time, and provides operator silence/acknowledge. It also latches an alarm-memory indicator and counts sounding events. All inputs come from combinational/asynchronous logic and are synchronised internally.

## Interface
Parameters:
- `ENTRY_DELAY`, 4: cycles in ENTRY before sounding; range 1..65535
- `SIREN_CYCLES`, 20: maximum SOUNDING duration in cycles; range 1..65535
- `PULSE_HALF`, 3: siren on/off half-period in cycles; range 1..65535
- `COOLDOWN_CYCLES`, 5: silent cycles after sounding before re-arm; range 1..65535

Ports:
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: reset, synchronous and active-low
- `alarm` in 1: alarm level from alarm core
- `active` in 1: armed level from alarm core
- `ack` in 1: operator silence/acknowledge, level
- `siren` out 1: pulsed siren drive
- `alarm_mem` out 1: latched "alarm has sounded" indicator
- `state` out 3: FSM state code
- `events` out 8: saturating count of SOUNDING entries

## Operation
- `alarm`, `active` and `ack` each pass through a 2-flop synchroniser (`*_s`), reset to 0.
- All outputs are registered. Reset values: `siren`=0, `alarm_mem`=0, `state`=0, `events`=0, timers=0.
- States: DISARMED=0, ARMED=1, ENTRY=2, SOUNDING=3, COOLDOWN=4. Codes 5-7 are illegal and go to DISARMED on the next edge.
- Priority per edge: (1) reset, (2) `active_s`=0, (3) `ack_s`, (4) timer expiry / `alarm_s`.
- Any state with `active_s`=0 goes to DISARMED. `siren` is 0 the same edge and the timer is cleared.
- DISARMED:
  - `active_s`=1 goes to ARMED.
  - `ack_s`=1 clears `alarm_mem`.
- ARMED:
  - `alarm_s`=1 goes to ENTRY and loads the timer.
  - `ack_s`=1 clears `alarm_mem`.
- ENTRY:
  - Lasts exactly ENTRY_DELAY cycles, then goes to SOUNDING.
  - `alarm_s` deasserting does not abort; only disarm aborts.
  - `ack_s` is ignored.
- SOUNDING:
  - On entry: set `alarm_mem`=1 and increment `events`, saturating at 255.
  - Lasts at most SIREN_CYCLES cycles, then goes to COOLDOWN.
  - `ack_s`=1 goes to COOLDOWN on the next edge; `alarm_mem` is kept.
  - `siren`=1 for the first PULSE_HALF cycles, 0 for the next PULSE_HALF, repeating. The phase restarts at every SOUNDING entry.
- COOLDOWN:
  - `siren`=0; lasts COOLDOWN_CYCLES cycles, then goes to ARMED.
  - `alarm_s` is ignored.
  - If `alarm_s` is still 1 in ARMED, the cycle repeats (ENTRY again).
- Timer: 16-bit down-counter, loaded with N-1 on state entry. The state exits on the edge where the timer reads 0.

## Timing
- Input to synchronised signal: an input stable before edge E1 is visible as `*_s` after edge E2. The FSM reacts at E3, i.e. 3-edge latency from input to `state` change.
- Occupancy: ENTRY covers exactly ENTRY_DELAY cycles; SOUNDING covers at most SIREN_CYCLES; COOLDOWN covers exactly COOLDOWN_CYCLES.
- `siren` rises on the same edge `state` becomes 3. It falls on the same edge `state` leaves 3.
- Disarm during any state: `state`=0 and `siren`=0 three edges after `active` falls.
- Simultaneous events:
  - `ack_s` and timer expiry in SOUNDING: go to COOLDOWN (same result either way).
  - `active_s`=0 and `ack_s`=1: go to DISARMED, and `alarm_mem` is not cleared that edge.
- Reset asserted mid-operation: all outputs return to reset values on that edge; `events` is cleared.
- A SIREN_CYCLES that is not a multiple of 2·PULSE_HALF truncates the final pulse.

## Test plan
1. Reset, `active`=1, then `alarm`=1 pulse of 1 cycle → `state` 1→2; ENTRY for 4 cycles; SOUNDING 20 cycles with `siren` pattern 111000 repeating, ending 11; COOLDOWN 5 cycles; ARMED; `events`=1, `alarm_mem`=1.
2. Trigger alarm, drop `active` while in ENTRY → DISARMED 3 edges later; `siren` never 1; `events`=0, `alarm_mem`=0.
3. In SOUNDING cycle 7, assert `ack` → COOLDOWN 3 edges later and `siren`=0. Then in ARMED with `ack` held → `alarm_mem` clears.
4. Hold `alarm`=1 continuously for 200 cycles → repeated ENTRY/SOUNDING/COOLDOWN loops of 29 cycles each; `events` increments per loop.
5. Force 300 trigger loops → `events` saturates at 255.
6. Assert `rst_n`=0 mid-SOUNDING → next edge `siren`=0, `state`=0, `events`=0, `alarm_mem`=0.

Source files
------------

// File: rtl/alarm_siren_controller.sv
// alarm_siren_controller
// Sits downstream of the home alarm core. It adds an entry delay, drives a
// pulsed siren for a bounded time, and supports operator silence/acknowledge.
// It also keeps an alarm-memory flag and a saturating count of sounding
// events. The alarm, active and ack inputs are asynchronous, so each passes
// through a two-flop synchroniser before the FSM uses it.
module alarm_siren_controller #(
  parameter int unsigned ENTRY_DELAY     = 4,
  parameter int unsigned SIREN_CYCLES    = 20,
  parameter int unsigned PULSE_HALF      = 3,
  parameter int unsigned COOLDOWN_CYCLES = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       alarm,
  input  logic       active,
  input  logic       ack,
  output logic       siren,
  output logic       alarm_mem,
  output logic [2:0] state,
  output logic [7:0] events
);

  // State codes are visible on the state port, so they stay fixed.
  localparam logic [2:0] DISARMED = 3'd0;
  localparam logic [2:0] ARMED    = 3'd1;
  localparam logic [2:0] ENTRY    = 3'd2;
  localparam logic [2:0] SOUNDING = 3'd3;
  localparam logic [2:0] COOLDOWN = 3'd4;

  // The timers are loaded with N-1, so a state exits on the edge where the
  // timer reads 0. That edge closes the Nth cycle.
  localparam logic [15:0] ENTRY_LOAD = 16'(ENTRY_DELAY - 1);
  localparam logic [15:0] SIREN_LOAD = 16'(SIREN_CYCLES - 1);
  localparam logic [15:0] PULSE_LOAD = 16'(PULSE_HALF - 1);
  localparam logic [15:0] COOL_LOAD  = 16'(COOLDOWN_CYCLES - 1);

  logic alarm_m, alarm_s;
  logic active_m, active_s;
  logic ack_m, ack_s;

  logic [15:0] timer, timer_d;
  logic [15:0] phase, phase_d;
  logic [2:0]  state_d;
  logic        siren_d;
  logic        mem_d;
  logic [7:0]  events_d;

  // Two-flop synchronisers for the asynchronous inputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alarm_m  <= 1'b0;
      alarm_s  <= 1'b0;
      active_m <= 1'b0;
      active_s <= 1'b0;
      ack_m    <= 1'b0;
      ack_s    <= 1'b0;
    end else begin
      alarm_m  <= alarm;
      alarm_s  <= alarm_m;
      active_m <= active;
      active_s <= active_m;
      ack_m    <= ack;
      ack_s    <= ack_m;
    end
  end

  // Next-state logic. Events are handled in this order: disarm, then
  // acknowledge, then timer expiry or alarm.
  always_comb begin
    state_d  = state;
    timer_d  = timer;
    phase_d  = phase;
    siren_d  = siren;
    mem_d    = alarm_mem;
    events_d = events;

    if (!active_s) begin
      state_d = DISARMED;
      timer_d = '0;
      phase_d = '0;
      siren_d = 1'b0;
    end else begin
      case (state)
        DISARMED: begin
          state_d = ARMED;
          if (ack_s) mem_d = 1'b0;
        end

        ARMED: begin
          if (ack_s) begin
            mem_d = 1'b0;
          end else if (alarm_s) begin
            state_d = ENTRY;
            timer_d = ENTRY_LOAD;
          end
        end

        // An alarm that drops during ENTRY does not abort it.
        // Only a disarm does.
        ENTRY: begin
          if (timer == '0) begin
            state_d = SOUNDING;
            timer_d = SIREN_LOAD;
            phase_d = PULSE_LOAD;
            siren_d = 1'b1;
            mem_d   = 1'b1;
            if (events != '1) events_d = events + 8'd1;
          end else begin
            timer_d = timer - 16'd1;
          end
        end

        SOUNDING: begin
          if (ack_s || timer == '0) begin
            state_d = COOLDOWN;
            timer_d = COOL_LOAD;
            phase_d = '0;
            siren_d = 1'b0;
          end else begin
            timer_d = timer - 16'd1;
            if (phase == '0) begin
              siren_d = ~siren;
              phase_d = PULSE_LOAD;
            end else begin
              phase_d = phase - 16'd1;
            end
          end
        end

        COOLDOWN: begin
          siren_d = 1'b0;
          if (timer == '0) begin
            state_d = ARMED;
            timer_d = '0;
          end else begin
            timer_d = timer - 16'd1;
          end
        end

        // Codes 5 to 7 are illegal. They recover to DISARMED.
        default: begin
          state_d = DISARMED;
          timer_d = '0;
          phase_d = '0;
          siren_d = 1'b0;
        end
      endcase
    end
  end

  // State, timers and the registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= DISARMED;
      timer     <= '0;
      phase     <= '0;
      siren     <= 1'b0;
      alarm_mem <= 1'b0;
      events    <= '0;
    end else begin
      state     <= state_d;
      timer     <= timer_d;
      phase     <= phase_d;
      siren     <= siren_d;
      alarm_mem <= mem_d;
      events    <= events_d;
    end
  end

endmodule

// File: tb/tb_alarm_siren_controller.sv
// Directed bench for alarm_siren_controller. It uses the default parameters:
// ENTRY 4, SIREN 20, PULSE_HALF 3, COOLDOWN 5.
module tb_alarm_siren_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       alarm;
  logic       active;
  logic       ack;
  logic       siren;
  logic       alarm_mem;
  logic [2:0] state;
  logic [7:0] events;

  int n_checks = 0;
  int n_fail   = 0;

  alarm_siren_controller #(
    .ENTRY_DELAY(4),
    .SIREN_CYCLES(20),
    .PULSE_HALF(3),
    .COOLDOWN_CYCLES(5)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .alarm(alarm),
    .active(active),
    .ack(ack),
    .siren(siren),
    .alarm_mem(alarm_mem),
    .state(state),
    .events(events)
  );

  always #5 clk = ~clk;

  // Advance one rising edge, then settle. Inputs are driven and outputs
  // sampled at this point.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset;
    rst_n  = 1'b0;
    alarm  = 1'b0;
    active = 1'b0;
    ack    = 1'b0;
    ticks(3);
    rst_n = 1'b1;
  endtask

  // Tick until state equals s. A bound on the number of ticks counts as a
  // failed comparison if it runs out.
  task automatic wait_state(input logic [2:0] s, input int limit, input string name);
    int n = 0;
    while (state !== s && n < limit) begin
      tick();
      n++;
    end
    n_checks++;
    if (state !== s) begin
      n_fail++;
      $display("FAIL %s: state=%0d required=%0d after %0d cycles", name, state, s, limit);
    end
  endtask

  // Set active=1 and expect ARMED exactly three edges later.
  task automatic arm(input string name);
    active = 1'b1;
    ticks(2);
    n_checks++;
    if (state !== 3'd0) begin
      n_fail++;
      $display("FAIL %s_early: state=%0d required=0", name, state);
    end
    tick();
    n_checks++;
    if (state !== 3'd1) begin
      n_fail++;
      $display("FAIL %s_armed: state=%0d required=1", name, state);
    end
  endtask

  // Enter with the observed state in ENTRY cycle 1. Walk 4 ENTRY cycles,
  // 20 SOUNDING cycles and 5 COOLDOWN cycles, then expect ARMED.
  task automatic run_loop(input int exp_events, input bit held, input string name);
    logic [2:0] es;
    logic       ez;
    for (int c = 0; c < 29; c++) begin
      if (c < 4)       es = 3'd2;
      else if (c < 24) es = 3'd3;
      else             es = 3'd4;
      ez = (c >= 4 && c < 24 && ((c - 4) % 6) < 3);
      n_checks++;
      if (state !== es || siren !== ez) begin
        n_fail++;
        $display("FAIL %s_cycle%0d: state=%0d siren=%b required state=%0d siren=%b",
                 name, c, state, siren, es, ez);
      end
      tick();
    end
    n_checks++;
    if (state !== 3'd1 || events !== 8'(exp_events) || alarm_mem !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_end: state=%0d events=%0d mem=%b required state=1 events=%0d mem=1",
               name, state, events, alarm_mem, exp_events);
    end
    if (held) begin
      tick();
      n_checks++;
      if (state !== 3'd2) begin
        n_fail++;
        $display("FAIL %s_retrigger: state=%0d required=2", name, state);
      end
    end
  endtask

  // Reset state: every output is held at 0.
  task automatic test_reset;
    do_reset();
    n_checks++;
    if (state !== 3'd0 || siren !== 1'b0 || alarm_mem !== 1'b0 || events !== 8'd0) begin
      n_fail++;
      $display("FAIL reset: state=%0d siren=%b mem=%b events=%0d required all 0",
               state, siren, alarm_mem, events);
    end
  endtask

  // A one-cycle alarm pulse runs a full ENTRY/SOUNDING/COOLDOWN sequence.
  task automatic test_full_cycle;
    do_reset();
    arm("full_arm");
    alarm = 1'b1;
    tick();
    alarm = 1'b0;
    tick();
    n_checks++;
    if (state !== 3'd1) begin
      n_fail++;
      $display("FAIL full_latency: state=%0d required=1", state);
    end
    tick();
    run_loop(1, 1'b0, "full");
    ticks(3);
    n_checks++;
    if (state !== 3'd1 || siren !== 1'b0) begin
      n_fail++;
      $display("FAIL full_idle: state=%0d siren=%b required state=1 siren=0", state, siren);
    end
  endtask

  // Disarming during ENTRY aborts before the siren ever sounds.
  task automatic test_disarm_entry;
    do_reset();
    arm("dis_arm");
    alarm = 1'b1;
    ticks(3);
    n_checks++;
    if (state !== 3'd2) begin
      n_fail++;
      $display("FAIL dis_entry: state=%0d required=2", state);
    end
    active = 1'b0;
    alarm  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (state !== 3'd2 || siren !== 1'b0) begin
        n_fail++;
        $display("FAIL dis_wait%0d: state=%0d siren=%b required state=2 siren=0", i, state, siren);
      end
    end
    tick();
    n_checks++;
    if (state !== 3'd0 || siren !== 1'b0 || events !== 8'd0 || alarm_mem !== 1'b0) begin
      n_fail++;
      $display("FAIL dis_done: state=%0d siren=%b events=%0d mem=%b required 0/0/0/0",
               state, siren, events, alarm_mem);
    end
  endtask

  // Ack in SOUNDING cycle 7 silences the siren. Ack held into ARMED clears
  // alarm_mem.
  task automatic test_ack;
    do_reset();
    arm("ack_arm");
    alarm = 1'b1;
    tick();
    alarm = 1'b0;
    wait_state(3'd3, 12, "ack_reach_sounding");
    ticks(6);
    ack = 1'b1;
    ticks(2);
    n_checks++;
    if (state !== 3'd3 || siren !== 1'b1) begin
      n_fail++;
      $display("FAIL ack_latency: state=%0d siren=%b required state=3 siren=1", state, siren);
    end
    tick();
    n_checks++;
    if (state !== 3'd4 || siren !== 1'b0 || alarm_mem !== 1'b1) begin
      n_fail++;
      $display("FAIL ack_silence: state=%0d siren=%b mem=%b required 4/0/1", state, siren, alarm_mem);
    end
    ticks(5);
    n_checks++;
    if (state !== 3'd1 || alarm_mem !== 1'b1) begin
      n_fail++;
      $display("FAIL ack_rearm: state=%0d mem=%b required state=1 mem=1", state, alarm_mem);
    end
    tick();
    n_checks++;
    if (state !== 3'd1 || alarm_mem !== 1'b0 || events !== 8'd1) begin
      n_fail++;
      $display("FAIL ack_clear: state=%0d mem=%b events=%0d required 1/0/1", state, alarm_mem, events);
    end
    ack = 1'b0;
  endtask

  // A held alarm repeats the loop back to back.
  task automatic test_back_to_back;
    do_reset();
    arm("b2b_arm");
    alarm = 1'b1;
    wait_state(3'd2, 6, "b2b_reach_entry");
    for (int k = 1; k <= 6; k++) run_loop(k, 1'b1, $sformatf("b2b_loop%0d", k));
  endtask

  // Continues from the held alarm. The event count must stop at 255.
  task automatic test_saturate;
    ticks(300 * 30);
    n_checks++;
    if (events !== 8'd255) begin
      n_fail++;
      $display("FAIL saturate: events=%0d required=255", events);
    end
    alarm = 1'b0;
  endtask

  // Reset applied mid-SOUNDING clears every output on the next edge.
  task automatic test_reset_mid;
    do_reset();
    arm("rmid_arm");
    alarm = 1'b1;
    tick();
    alarm = 1'b0;
    wait_state(3'd3, 12, "rmid_reach_sounding");
    ticks(2);
    n_checks++;
    if (siren !== 1'b1 || events !== 8'd1 || alarm_mem !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_pre: siren=%b events=%0d mem=%b required 1/1/1", siren, events, alarm_mem);
    end
    rst_n = 1'b0;
    tick();
    n_checks++;
    if (state !== 3'd0 || siren !== 1'b0 || events !== 8'd0 || alarm_mem !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_post: state=%0d siren=%b events=%0d mem=%b required all 0",
               state, siren, events, alarm_mem);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n  = 1'b0;
    alarm  = 1'b0;
    active = 1'b0;
    ack    = 1'b0;
    test_reset();
    test_full_cycle();
    test_disarm_entry();
    test_ack();
    test_back_to_back();
    test_saturate();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
